// File: rtl/vga_pkg.sv
// Shared VGA constants: active geometry, pixel size, RGB444 field offsets and
// the fetch-state encoding used by the pixel feeder.
package vga_pkg;
    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
    localparam int PIX_BYTES = 2;

    localparam int RGB_B_LSB = 0;
    localparam int RGB_G_LSB = 4;
    localparam int RGB_R_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DONE
    } fetch_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head, synchronous flush and occupancy count.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             full, do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/vga_pixel_fetch.sv
// Streams one frame of 16-bit pixels from memory into a prefetch FIFO and hands
// one pixel per request to the timing stage, flagging underruns.
module vga_pixel_fetch #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          FRAME_PIX   = 307200,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] UNDER_COLOR = 16'h0F00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        pix_req,
    output logic [15:0] pixel,
    output logic        underrun,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata
);
    import vga_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int RW = $clog2(FRAME_PIX + 1);

    fetch_state_e  state;
    logic [RW-1:0] req_cnt;
    logic [CW-1:0] outstanding, out_next, drop_cnt, fifo_count;
    logic [15:0]   fifo_head;
    logic          fifo_empty, credit_ok, req_acc, push, pop;

    // Every in-flight read owns a FIFO slot, so the FIFO cannot overflow.
    assign credit_ok     = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(FIFO_DEPTH);
    assign mem_req_valid = (state == ST_FETCH) && credit_ok;
    assign req_acc       = mem_req_valid && mem_req_ready;
    assign push          = mem_rvalid && (drop_cnt == '0) && !frame_start;
    assign pop           = pix_req && !fifo_empty && !frame_start;

    always_comb begin
        out_next = outstanding;
        if (req_acc && !mem_rvalid)      out_next = outstanding + CW'(1);
        else if (!req_acc && mem_rvalid) out_next = outstanding - CW'(1);
    end

    sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (frame_start),
        .push  (push),
        .wdata (mem_rdata),
        .pop   (pop),
        .rdata (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            mem_addr    <= BASE_ADDR;
            req_cnt     <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            pixel       <= '0;
            underrun    <= 1'b0;
        end else begin
            outstanding <= out_next;
            if (frame_start) begin
                // Reads still in flight belong to the old frame; discard them on return.
                state    <= ST_FETCH;
                mem_addr <= BASE_ADDR;
                req_cnt  <= '0;
                drop_cnt <= out_next;
                underrun <= 1'b0;
            end else begin
                if (req_acc) begin
                    mem_addr <= mem_addr + 32'(PIX_BYTES);
                    req_cnt  <= req_cnt + RW'(1);
                    if (req_cnt == RW'(FRAME_PIX - 1)) state <= ST_DONE;
                end
                if (mem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                if (pix_req) begin
                    if (fifo_empty) begin
                        pixel    <= UNDER_COLOR;
                        underrun <= 1'b1;
                    end else begin
                        pixel <= fifo_head;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Randomized bench for vga_pixel_fetch with an in-order latency memory and a
// queue-based frame model checked against the DUT every cycle.
module tb_vga_pixel_fetch;
    localparam logic [31:0] BASE  = 32'hFFFF_FF00;
    localparam int          FRAME = 400;
    localparam int          DEPTH = 16;
    localparam logic [15:0] UNDER = 16'h0F00;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start, pix_req, mem_req_ready, mem_rvalid;
    logic [15:0] mem_rdata, pixel;
    logic        underrun, mem_req_valid;
    logic [31:0] mem_addr;

    vga_pixel_fetch #(.BASE_ADDR(BASE), .FRAME_PIX(FRAME), .FIFO_DEPTH(DEPTH),
                      .UNDER_COLOR(UNDER)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_req(pix_req),
        .pixel(pixel), .underrun(underrun), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] data; int due; } ret_t;
    ret_t mq[$];
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, lat_lo = 1, lat_hi = 1, gen = 0, acc_cnt = 0;
    logic [31:0] last_acc_addr;

    // Frame model: state 0 idle, 1 fetching, 2 done.
    int          m_st, m_rc, m_out, m_drop;
    logic [31:0] m_addr;
    logic [15:0] m_q[$];
    logic [15:0] m_pix;
    logic        m_ur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_rc = 0; m_out = 0; m_drop = 0;
        m_addr = BASE; m_q.delete(); m_pix = '0; m_ur = 1'b0;
    endtask

    function automatic logic model_valid();
        return (m_st == 1) && (m_q.size() + m_out < DEPTH);
    endfunction

    task automatic do_reset();
        rst = 1'b1; frame_start = 0; pix_req = 0; mem_req_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        #1;
        check("rst_valid", 32'(mem_req_valid), 32'd0);
        check("rst_addr", mem_addr, BASE);
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        mq.delete();
        model_reset();
        @(posedge clk); @(negedge clk);
        rst = 1'b0; cyc++;
    endtask

    task automatic tick(input logic fs, input logic pr, input logic rdy);
        logic        acc, rv;
        logic [15:0] rd;
        logic [31:0] idx;
        ret_t        r;
        check("mem_req_valid", 32'(mem_req_valid), 32'(model_valid()));
        check("mem_addr", mem_addr, m_addr);
        check("pixel", 32'(pixel), 32'(m_pix));
        check("underrun", 32'(underrun), 32'(m_ur));
        rv = 1'b0; rd = 16'(cyc * 7);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            r = mq.pop_front(); rv = 1'b1; rd = r.data;
        end
        frame_start = fs; pix_req = pr; mem_req_ready = rdy; mem_rvalid = rv; mem_rdata = rd;
        if (mem_req_valid && rdy) begin
            idx = (mem_addr - BASE) >> 1;
            r.data = {4'(gen), idx[11:0]};
            r.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
            mq.push_back(r);
            acc_cnt++;
            last_acc_addr = mem_addr;
        end
        acc = model_valid() && rdy;
        if (fs) begin
            m_out  = m_out + int'(acc) - int'(rv);
            m_drop = m_out;
            m_q.delete(); m_rc = 0; m_addr = BASE; m_ur = 1'b0; m_st = 1;
            gen++;
        end else begin
            if (pr) begin
                if (m_q.size() == 0) begin m_pix = UNDER; m_ur = 1'b1; end
                else m_pix = m_q.pop_front();
            end
            if (rv) begin
                if (m_drop > 0) m_drop--;
                else m_q.push_back(rd);
            end
            m_out = m_out + int'(acc) - int'(rv);
            if (acc) begin
                m_addr = m_addr + 32'd2; m_rc++;
                if (m_rc == FRAME) m_st = 2;
            end
        end
        @(posedge clk); @(negedge clk);
        cyc++;
    endtask

    initial begin
        int pops, c;
        logic [15:0] exp_px;
        do_reset();

        // Underrun before any data has returned, then cleared by frame_start.
        lat_lo = 5; lat_hi = 5;
        tick(1, 0, 1);
        tick(0, 1, 1);
        check("under_pixel", 32'(pixel), 32'h0000_0F00);
        check("under_flag", 32'(underrun), 32'd1);
        tick(1, 0, 1);
        check("under_clear", 32'(underrun), 32'd0);
        for (int i = 0; i < 3; i++) tick(0, 0, 1);
        check("prereset_valid", 32'(mem_req_valid), 32'd1);
        do_reset();

        // Fill with no consumer: exactly DEPTH requests, then valid stays low.
        lat_lo = 2; lat_hi = 2;
        tick(1, 0, 1);
        acc_cnt = 0;
        for (int i = 0; i < 40; i++) tick(0, 0, 1);
        check("fill_req_count", 32'(acc_cnt), 32'd16);
        check("fill_last_addr", last_acc_addr, 32'hFFFF_FF1E);
        check("fill_valid_low", 32'(mem_req_valid), 32'd0);

        // Restart with five reads in flight: all five must be discarded.
        tick(1, 0, 0);
        lat_lo = 8; lat_hi = 8; acc_cnt = 0;
        for (int i = 0; i < 5; i++) tick(0, 0, 1);
        check("inflight_count", 32'(acc_cnt), 32'd5);
        tick(1, 0, 0);
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 30; i++) tick(0, 0, 1);
        tick(0, 1, 1);
        exp_px = {4'(gen), 12'h000};
        check("first_after_drop", 32'(pixel), 32'(exp_px));

        // Whole frame with a stalling memory and a consumer every 4th cycle.
        lat_lo = 1; lat_hi = 6;
        tick(1, 0, 0);
        acc_cnt = 0; pops = 0; c = 0;
        while (pops < FRAME && c < 6000) begin
            if (c >= 20 && c % 4 == 0) begin
                tick(0, 1, $urandom_range(9, 0) < 7);
                exp_px = {4'(gen), 12'(pops)};
                check("frame_seq", 32'(pixel), 32'(exp_px));
                pops++;
            end else begin
                tick(0, 0, $urandom_range(9, 0) < 7);
            end
            c++;
        end
        check("frame_pops", 32'(pops), 32'(FRAME));
        for (int i = 0; i < 5; i++) tick(0, 0, 1);
        check("frame_req_total", 32'(acc_cnt), 32'(FRAME));
        check("frame_done_valid", 32'(mem_req_valid), 32'd0);
        check("frame_underrun", 32'(underrun), 32'd0);

        // Fully random traffic including restarts colliding with requests.
        lat_lo = 1; lat_hi = 8;
        for (int i = 0; i < 1500; i++)
            tick($urandom_range(99, 0) == 0, $urandom_range(2, 0) == 0, $urandom_range(1, 0) == 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
